// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: walks one external 1-bit ALU slice across WIDTH bits,
// LSB first, chaining the carry through a register and collecting result bits.
//
// state  | meaning
// S_IDLE | waiting for start; outputs hold last result
// S_RUN  | one operand bit per clock through the slice, bit index = cnt
// S_DONE | single-cycle done pulse; result and flags valid
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       func,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_sa,
    output logic             slice_sb,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    output logic             slice_sm,
    input  logic             slice_res,
    input  logic             slice_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] F_AND   = 3'b000;
    localparam logic [2:0] F_OR    = 3'b001;
    localparam logic [2:0] F_ADD   = 3'b010;
    localparam logic [2:0] F_SUB   = 3'b011;
    localparam logic [2:0] F_NOR   = 3'b100;
    localparam logic [2:0] F_NAND  = 3'b101;
    localparam logic [2:0] F_SLT   = 3'b110;
    localparam logic [2:0] F_PASSB = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, shift_q, fin_res;
    logic [2:0]       func_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             ovf_raw;
    logic             last_bit;

    assign last_bit = (cnt == LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state, status outputs and slice controls (registered state only)
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_sa  = 1'b0;
        slice_sb  = 1'b0;
        slice_cin = 1'b0;
        slice_op  = 2'b00;
        slice_sm  = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                busy      = 1'b1;
                slice_a   = a_q[cnt];
                slice_b   = b_q[cnt];
                slice_cin = carry_q;
                case (func_q)
                    F_AND:   slice_op = 2'b00;
                    F_OR:    slice_op = 2'b01;
                    F_ADD:   slice_op = 2'b10;
                    F_SUB, F_SLT: begin
                        slice_op = 2'b10;
                        slice_sb = 1'b1;
                    end
                    F_NOR: begin
                        slice_op = 2'b00;
                        slice_sa = 1'b1;
                        slice_sb = 1'b1;
                    end
                    F_NAND: begin
                        slice_op = 2'b01;
                        slice_sa = 1'b1;
                        slice_sb = 1'b1;
                    end
                    F_PASSB: begin
                        slice_op = 2'b11;
                        slice_sm = b_q[cnt];
                    end
                    default: slice_op = 2'b00;
                endcase
                if (last_bit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Final result assembly from the MSB slice output; SLT collapses to sign^ovf
    always_comb begin
        ovf_raw = carry_q ^ slice_cout;
        fin_res = {slice_res, shift_q[WIDTH-2:0]};
        if (func_q == F_SLT) fin_res = {{(WIDTH-1){1'b0}}, slice_res ^ ovf_raw};
    end

    // Operand latch, bit counter, carry chain, shift register and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            shift_q <= '0;
            result  <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q     <= a;
                    b_q     <= b;
                    func_q  <= func;
                    cnt     <= '0;
                    shift_q <= '0;
                    carry_q <= (func == F_SUB) || (func == F_SLT);
                end
                S_RUN: begin
                    shift_q[cnt] <= slice_res;
                    carry_q      <= slice_cout;
                    cnt          <= cnt + 1'b1;
                    if (last_bit) begin
                        result <= fin_res;
                        c_out  <= (func_q == F_ADD) || (func_q == F_SUB) || (func_q == F_SLT)
                                  ? slice_cout : 1'b0;
                        ovf    <= (func_q == F_ADD) || (func_q == F_SUB) ? ovf_raw : 1'b0;
                        zero   <= (fin_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Testbench for serial_alu_seq: models the 1-bit slice, predicts every output
// cycle by cycle from word-level arithmetic, and runs directed plus random ops.
module tb_serial_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] a, b;
    logic [2:0]   func;
    logic         busy, done, c_out, ovf, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_sa, slice_sb, slice_cin, slice_sm;
    logic [1:0]   slice_op;
    logic         slice_res, slice_cout;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // model state: 0 idle, 1..W running bit (phase-1), W+1 done cycle
    int           m_phase = 0;
    logic [W-1:0] m_a, m_b;
    logic [2:0]   m_f;
    logic [W-1:0] e_res;
    logic         e_c, e_v, e_z;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .func(func),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .ovf(ovf), .zero(zero),
        .slice_a(slice_a), .slice_b(slice_b), .slice_sa(slice_sa), .slice_sb(slice_sb),
        .slice_cin(slice_cin), .slice_op(slice_op), .slice_sm(slice_sm),
        .slice_res(slice_res), .slice_cout(slice_cout)
    );

    always #5 clk = ~clk;

    // External 1-bit ALU slice
    always_comb begin
        logic ap, bp;
        ap = slice_a ^ slice_sa;
        bp = slice_b ^ slice_sb;
        slice_cout = (ap & bp) | (ap & slice_cin) | (bp & slice_cin);
        case (slice_op)
            2'b00:   slice_res = ap & bp;
            2'b01:   slice_res = ap | bp;
            2'b10:   slice_res = ap ^ bp ^ slice_cin;
            default: slice_res = slice_sm;
        endcase
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // {sa, sb, op} expected for each function code
    function automatic logic [3:0] ctl(input logic [2:0] f);
        case (f)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0010;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b1100;
            3'd5:    return 4'b1101;
            3'd6:    return 4'b0110;
            default: return 4'b0011;
        endcase
    endfunction

    // carry entering bit i of (A' + B' + c0) with the operand inversions of f
    function automatic logic cin_at(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic [2:0] f, input int i);
        logic [3:0] c;
        logic [W:0] xp, yp, m, s;
        c  = ctl(f);
        xp = {1'b0, c[3] ? ~x : x};
        yp = {1'b0, c[2] ? ~y : y};
        m  = (W+1)'((1 << i) - 1);
        s  = (xp & m) + (yp & m) + (W+1)'((f == 3'd3) || (f == 3'd6));
        return s[i];
    endfunction

    function automatic void golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [2:0] f, output logic [W-1:0] r,
                                   output logic c, output logic v);
        logic [W:0] s;
        r = '0; c = 1'b0; v = 1'b0;
        case (f)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd4: r = ~(x | y);
            3'd5: r = ~(x & y);
            3'd7: r = y;
            3'd2: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd3: begin
                s = {1'b0, x} + {1'b0, ~y} + 1'b1;
                r = s[W-1:0]; c = s[W];
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            default: begin
                s = {1'b0, x} + {1'b0, ~y} + 1'b1;
                c = s[W];
                r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            end
        endcase
    endfunction

    // Reference model advanced on each active edge
    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            e_res = '0; e_c = 1'b0; e_v = 1'b0; e_z = 1'b1;
        end else if (m_phase == 0) begin
            if (start) begin
                m_a = a; m_b = b; m_f = func;
                m_phase = 1;
            end
        end else if (m_phase <= W) begin
            m_phase++;
            if (m_phase == W + 1) begin
                golden(m_a, m_b, m_f, e_res, e_c, e_v);
                e_z = (e_res == '0);
            end
        end else begin
            m_phase = 0;
        end
    end

    // Compare every output against the model on the inactive edge
    always @(negedge clk) begin
        if (chk_en) begin
            int i;
            logic [3:0] c;
            if (done === 1'b1) done_cnt++;
            check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= W));
            check("done", 32'(done), 32'(m_phase == W + 1));
            check("result", 32'(result), 32'(e_res));
            check("c_out", 32'(c_out), 32'(e_c));
            check("ovf", 32'(ovf), 32'(e_v));
            check("zero", 32'(zero), 32'(e_z));
            if (m_phase >= 1 && m_phase <= W) begin
                i = m_phase - 1;
                c = ctl(m_f);
                check("slice_a", 32'(slice_a), 32'(m_a[i]));
                check("slice_b", 32'(slice_b), 32'(m_b[i]));
                check("slice_sa_sb_op", 32'({slice_sa, slice_sb, slice_op}), 32'(c));
                check("slice_sm", 32'(slice_sm), 32'((m_f == 3'd7) ? m_b[i] : 1'b0));
                check("slice_cin", 32'(slice_cin), 32'(cin_at(m_a, m_b, m_f, i)));
            end else begin
                check("slice_idle",
                      32'({slice_a, slice_b, slice_sa, slice_sb, slice_cin, slice_op, slice_sm}), 32'(0));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_phase != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 32'(m_phase), 32'(0));
    endtask

    // Returns number of edges from accept to done (expected W)
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [2:0] tf,
                          output int lat);
        wait_idle();
        a = ta; b = tb_; func = tf; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < W + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", 32'(done), 32'(1));
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, dc;
        logic [W-1:0] gr;
        logic gc, gv;

        // pin the word-level model with hand-computed values
        golden(8'h7F, 8'h01, 3'd2, gr, gc, gv);
        check("pin_add", 32'({gr, gc, gv}), 32'({8'h80, 1'b0, 1'b1}));
        golden(8'h05, 8'h07, 3'd3, gr, gc, gv);
        check("pin_sub", 32'({gr, gc, gv}), 32'({8'hFE, 1'b0, 1'b0}));
        golden(8'h80, 8'h01, 3'd6, gr, gc, gv);
        check("pin_slt", 32'(gr), 32'(8'h01));
        check("pin_cin", 32'(cin_at(8'h7F, 8'h01, 3'd2, 7)), 32'(1));

        rst = 1'b1; start = 1'b0; a = '0; b = '0; func = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_result", 32'(result), 32'(0));
        check("rst_zero", 32'(zero), 32'(1));
        check("rst_slice", 32'({slice_a, slice_b, slice_sa, slice_sb, slice_cin, slice_op, slice_sm}), 32'(0));

        run_op(8'h7F, 8'h01, 3'd2, lat);
        check("add1_lat", 32'(lat), 32'(W));
        check("add1", 32'({result, c_out, ovf, zero}), 32'({8'h80, 3'b010}));
        run_op(8'hFF, 8'h01, 3'd2, lat);
        check("add2", 32'({result, c_out, ovf, zero}), 32'({8'h00, 3'b101}));
        run_op(8'h05, 8'h07, 3'd3, lat);
        check("sub", 32'({result, c_out, ovf}), 32'({8'hFE, 2'b00}));
        run_op(8'h80, 8'h01, 3'd6, lat);
        check("slt1", 32'(result), 32'(8'h01));
        run_op(8'h01, 8'h80, 3'd6, lat);
        check("slt2", 32'({result, zero}), 32'({8'h00, 1'b1}));
        run_op(8'hF0, 8'h3C, 3'd0, lat); check("and",   32'({result, c_out, ovf}), 32'({8'h30, 2'b00}));
        run_op(8'hF0, 8'h3C, 3'd1, lat); check("or",    32'({result, c_out, ovf}), 32'({8'hFC, 2'b00}));
        run_op(8'hF0, 8'h3C, 3'd4, lat); check("nor",   32'({result, c_out, ovf}), 32'({8'h03, 2'b00}));
        run_op(8'hF0, 8'h3C, 3'd5, lat); check("nand",  32'({result, c_out, ovf}), 32'({8'hCF, 2'b00}));
        run_op(8'hF0, 8'h3C, 3'd7, lat); check("passb", 32'({result, c_out, ovf}), 32'({8'h3C, 2'b00}));

        // start while busy and during done must be ignored
        wait_idle();
        dc = done_cnt;
        a = 8'h11; b = 8'h22; func = 3'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 a = 8'hAA; b = 8'h55; func = 3'd0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 20 && m_phase != W + 1; n++) begin
            @(posedge clk); #1;
        end
        a = 8'h01; b = 8'h01; func = 3'd3; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ignore_result", 32'(result), 32'(8'h33));
        check("ignore_busy", 32'(busy), 32'(0));
        check("ignore_done_cnt", 32'(done_cnt - dc), 32'(1));

        // abort in RUN at bit 3
        wait_idle();
        dc = done_cnt;
        a = 8'h12; b = 8'h34; func = 3'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int n = 0; n < 20 && m_phase != 4; n++) begin
            @(posedge clk); #1;
        end
        check("abort_at_bit3", 32'(m_phase), 32'(4));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_state", 32'({busy, done, result, c_out, ovf, zero}), 32'({2'b00, 8'h00, 3'b001}));
        repeat (12) @(posedge clk);
        #1 check("abort_no_done", 32'(done_cnt - dc), 32'(0));
        run_op(8'h01, 8'h01, 3'd2, lat);
        check("after_abort", 32'(result), 32'(8'h02));

        // rst and start together: rst wins
        rst = 1'b1; start = 1'b1; a = 8'h0F; b = 8'h0F; func = 3'd2;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        check("rst_start_busy", 32'(busy), 32'(0));

        // randomized ops, all cycles compared against the model
        for (int k = 0; k < 60; k++) begin
            run_op(W'($urandom), W'($urandom), 3'($urandom_range(7, 0)), lat);
            check("rand_lat", 32'(lat), 32'(W));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
